// File: rtl/l1ca_acq_scheduler.sv
// GPS L1 C/A acquisition scheduler: walks the enabled PRNs of a sweep through one search engine.
// Optional per-SV watchdog is compiled in when L1CA_ACQ_TIMEOUT_EN is defined.
module l1ca_acq_scheduler #(
    parameter int unsigned TIMEOUT_CYCLES = 50_000_000
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        sweep_start,
    input  logic [31:0] sv_mask,
    input  logic [31:0] threshold,
    output logic        search_start,
    output logic [4:0]  search_sv,
    input  logic        search_busy,
    input  logic [31:0] search_acc,
    input  logic [10:0] search_code,
    input  logic [4:0]  search_dop,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [4:0]  res_sv,
    output logic [10:0] res_code,
    output logic [4:0]  res_dop,
    output logic [31:0] res_power,
    output logic [31:0] found_mask,
    output logic        sweep_busy,
    output logic        sweep_done,
    output logic        timeout_flag
);

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > (1 << 26)) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must lie in 1..2**26 to fit the 26-bit watchdog");
    end

    typedef enum logic [2:0] {
        StIdle,
        StSelect,
        StLaunch,
        StWaitBusy,
        StWaitDone,
        StEvaluate,
        StReport
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pending_q, pending_d;
    logic [31:0] thresh_q, thresh_d;
    logic [31:0] found_q, found_d;
    logic [31:0] acc_q, acc_d;
    logic [10:0] code_q, code_d;
    logic [4:0]  dop_q, dop_d;
    logic [4:0]  sv_q, sv_d;
    logic        done_q, done_d;
    logic        pick_valid;
    logic [4:0]  pick_idx;
    logic        timed_out;

    // Descending scan so the lowest set bit is the last one written.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        for (int i = 31; i >= 0; i--) begin
            if (pending_q[i]) begin
                pick_valid = 1'b1;
                pick_idx   = 5'(i);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        thresh_d  = thresh_q;
        found_d   = found_q;
        acc_d     = acc_q;
        code_d    = code_q;
        dop_d     = dop_q;
        sv_d      = sv_q;
        done_d    = 1'b0;
        case (state_q)
            StIdle: begin
                if (sweep_start) begin
                    pending_d = sv_mask;
                    thresh_d  = threshold;
                    found_d   = '0;
                    state_d   = StSelect;
                end
            end
            StSelect: begin
                if (pick_valid) begin
                    sv_d                = pick_idx;
                    pending_d[pick_idx] = 1'b0;
                    state_d             = StLaunch;
                end else begin
                    done_d  = 1'b1;
                    state_d = StIdle;
                end
            end
            StLaunch: state_d = StWaitBusy;
            StWaitBusy: begin
                if (timed_out) begin
                    state_d = StSelect;
                end else if (search_busy) begin
                    state_d = StWaitDone;
                end
            end
            StWaitDone: begin
                if (timed_out) begin
                    state_d = StSelect;
                end else if (!search_busy) begin
                    acc_d   = search_acc;
                    code_d  = search_code;
                    dop_d   = search_dop;
                    state_d = StEvaluate;
                end
            end
            StEvaluate: begin
                if (acc_q > thresh_q) begin
                    found_d[sv_q] = 1'b1;
                    state_d       = StReport;
                end else begin
                    state_d = StSelect;
                end
            end
            StReport: begin
                if (res_ready) begin
                    state_d = StSelect;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q   <= StIdle;
            pending_q <= '0;
            thresh_q  <= '0;
            found_q   <= '0;
            acc_q     <= '0;
            code_q    <= '0;
            dop_q     <= '0;
            sv_q      <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            thresh_q  <= thresh_d;
            found_q   <= found_d;
            acc_q     <= acc_d;
            code_q    <= code_d;
            dop_q     <= dop_d;
            sv_q      <= sv_d;
            done_q    <= done_d;
        end
    end

`ifdef L1CA_ACQ_TIMEOUT_EN
    localparam logic [25:0] TimeoutLast = 26'(TIMEOUT_CYCLES - 1);

    logic [25:0] wd_cnt_q;
    logic        timeout_q;
    logic        waiting;

    assign waiting   = (state_q == StWaitBusy) || (state_q == StWaitDone);
    assign timed_out = waiting && (wd_cnt_q == TimeoutLast);

    always_ff @(posedge clk) begin
        if (!nrst) begin
            wd_cnt_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (state_q == StLaunch) begin
                wd_cnt_q <= '0;
            end else if (waiting) begin
                wd_cnt_q <= wd_cnt_q + 26'd1;
            end
            if (state_q == StIdle && sweep_start) begin
                timeout_q <= 1'b0;
            end else if (timed_out) begin
                timeout_q <= 1'b1;
            end
        end
    end

    assign timeout_flag = timeout_q;
`else
    assign timed_out    = 1'b0;
    assign timeout_flag = 1'b0;
`endif

    assign search_start = (state_q == StLaunch);
    assign search_sv    = sv_q;
    assign res_valid    = (state_q == StReport);
    assign res_sv       = sv_q;
    assign res_code     = code_q;
    assign res_dop      = dop_q;
    assign res_power    = acc_q;
    assign found_mask   = found_q;
    assign sweep_busy   = (state_q != StIdle);
    assign sweep_done   = done_q;

endmodule

// File: tb/tb_l1ca_acq_scheduler.sv
// Self-checking bench for l1ca_acq_scheduler: directed sweeps plus randomized sweeps against
// a per-sweep expectation built from the mask, threshold and engine tables.
module tb_l1ca_acq_scheduler;

    logic        clk;
    logic        nrst;
    logic        sweep_start;
    logic [31:0] sv_mask;
    logic [31:0] threshold;
    logic        search_start;
    logic [4:0]  search_sv;
    logic        search_busy;
    logic [31:0] search_acc;
    logic [10:0] search_code;
    logic [4:0]  search_dop;
    logic        res_valid;
    logic        res_ready;
    logic [4:0]  res_sv;
    logic [10:0] res_code;
    logic [4:0]  res_dop;
    logic [31:0] res_power;
    logic [31:0] found_mask;
    logic        sweep_busy;
    logic        sweep_done;
    logic        timeout_flag;

    l1ca_acq_scheduler #(.TIMEOUT_CYCLES(100)) dut (
        .clk          (clk),
        .nrst         (nrst),
        .sweep_start  (sweep_start),
        .sv_mask      (sv_mask),
        .threshold    (threshold),
        .search_start (search_start),
        .search_sv    (search_sv),
        .search_busy  (search_busy),
        .search_acc   (search_acc),
        .search_code  (search_code),
        .search_dop   (search_dop),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .res_sv       (res_sv),
        .res_code     (res_code),
        .res_dop      (res_dop),
        .res_power    (res_power),
        .found_mask   (found_mask),
        .sweep_busy   (sweep_busy),
        .sweep_done   (sweep_done),
        .timeout_flag (timeout_flag)
    );

    typedef struct {
        logic [4:0]  sv;
        logic [10:0] code;
        logic [4:0]  dop;
        logic [31:0] pwr;
    } res_t;

    int          chk = 0;
    int          errs = 0;
    int          cyc = 0;
    int          n_starts = 0;
    int          n_done = 0;
    int          n_res = 0;
    int          last_start = -1;
    int          last_gap = 0;
    int          exp_nres = 0;
    int          ready_mode = 1;   // 0 random, 1 always ready, 2 never ready
    bit          mid_start_en = 0;
    logic        exp_tflag = 1'b0;
    logic [31:0] exp_found = '0;
    int          exp_launch[$];
    res_t        exp_res[$];

    // Engine model configuration and per-PRN result tables
    int          eng_dly_max = 0;
    int          eng_len_min = 2;
    int          eng_len_max = 2;
    bit          eng_stuck = 0;
    logic [31:0] eng_acc[32];
    logic [10:0] eng_code[32];
    logic [4:0]  eng_dop[32];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #900_000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Search engine: after a start, optional delay, busy for a while with junk data, then result.
    initial begin
        int e_sv, e_d, e_len;
        search_busy = 1'b0;
        search_acc  = '0;
        search_code = '0;
        search_dop  = '0;
        forever begin
            @(posedge clk);
            #1;
            if (search_start && !eng_stuck) begin
                e_sv  = int'(search_sv);
                e_d   = int'($urandom_range(eng_dly_max, 0));
                e_len = int'($urandom_range(eng_len_max, eng_len_min));
                repeat (e_d) begin
                    @(posedge clk);
                    #1;
                end
                search_busy = 1'b1;
                search_acc  = $urandom;
                search_code = 11'($urandom);
                search_dop  = 5'($urandom);
                repeat (e_len) begin
                    @(posedge clk);
                    #1;
                end
                search_acc  = eng_acc[e_sv];
                search_code = eng_code[e_sv];
                search_dop  = eng_dop[e_sv];
                search_busy = 1'b0;
            end else begin
                search_busy = eng_stuck;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        chk++;
        assert (obs === expv) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // One clock: observe outputs just after the edge and score launches, results and done pulses.
    task automatic step();
        int   expv;
        res_t h;
        @(posedge clk);
        #1;
        cyc++;
        case (ready_mode)
            0:       res_ready = 1'($urandom_range(1, 0));
            1:       res_ready = 1'b1;
            default: res_ready = 1'b0;
        endcase
        if (search_start) begin
            expv = (exp_launch.size() > 0) ? exp_launch.pop_front() : -1;
            check("search_sv", {27'd0, search_sv}, expv);
            if (last_start >= 0) last_gap = cyc - last_start;
            last_start = cyc;
            n_starts++;
        end
        if (res_valid) begin
            if (exp_res.size() > 0) begin
                h = exp_res[0];
                check("res_sv", {27'd0, res_sv}, {27'd0, h.sv});
                check("res_code", {21'd0, res_code}, {21'd0, h.code});
                check("res_dop", {27'd0, res_dop}, {27'd0, h.dop});
                check("res_power", res_power, h.pwr);
                if (res_ready) begin
                    void'(exp_res.pop_front());
                    n_res++;
                end
            end else begin
                check("unexpected_res_valid", {31'd0, res_valid}, 32'd0);
            end
        end
        if (sweep_done) n_done++;
    endtask

    task automatic check_reset_outputs();
        check("rst_search_start", {31'd0, search_start}, 32'd0);
        check("rst_search_sv", {27'd0, search_sv}, 32'd0);
        check("rst_res_valid", {31'd0, res_valid}, 32'd0);
        check("rst_res_sv", {27'd0, res_sv}, 32'd0);
        check("rst_res_code", {21'd0, res_code}, 32'd0);
        check("rst_res_dop", {27'd0, res_dop}, 32'd0);
        check("rst_res_power", res_power, 32'd0);
        check("rst_found_mask", found_mask, 32'd0);
        check("rst_sweep_busy", {31'd0, sweep_busy}, 32'd0);
        check("rst_sweep_done", {31'd0, sweep_done}, 32'd0);
        check("rst_timeout_flag", {31'd0, timeout_flag}, 32'd0);
    endtask

    // Expectation: enabled PRNs searched in ascending order; a result for each power > threshold.
    task automatic start_sweep(input logic [31:0] mask, input logic [31:0] thr);
        res_t r;
        exp_launch.delete();
        exp_res.delete();
        exp_found = '0;
        exp_nres  = 0;
        for (int i = 0; i < 32; i++) begin
            if (mask[i]) begin
                exp_launch.push_back(i);
                if (eng_acc[i] > thr) begin
                    r.sv   = 5'(i);
                    r.code = eng_code[i];
                    r.dop  = eng_dop[i];
                    r.pwr  = eng_acc[i];
                    exp_res.push_back(r);
                    exp_found[i] = 1'b1;
                    exp_nres++;
                end
            end
        end
        n_done      = 0;
        n_res       = 0;
        last_start  = -1;
        sv_mask     = mask;
        threshold   = thr;
        sweep_start = 1'b1;
        step();
        sweep_start = 1'b0;
        sv_mask     = $urandom;
        threshold   = $urandom;
    endtask

    task automatic finish_sweep();
        int guard = 0;
        while (n_done == 0 && guard < 5000) begin
            if (mid_start_en && sweep_busy && ($urandom_range(15, 0) == 0)) begin
                sweep_start = 1'b1;
                sv_mask     = $urandom;
                threshold   = $urandom;
            end
            step();
            sweep_start = 1'b0;
            guard++;
        end
        check("sweep_done_count", n_done, 1);
        check("launches_left", exp_launch.size(), 0);
        check("results_left", exp_res.size(), 0);
        check("result_count", n_res, exp_nres);
        check("found_mask", found_mask, exp_found);
        check("idle_after_done", {31'd0, sweep_busy}, 32'd0);
        check("timeout_flag", {31'd0, timeout_flag}, {31'd0, exp_tflag});
        step();
        check("done_one_cycle", {31'd0, sweep_done}, 32'd0);
    endtask

    initial begin
        int s0;
        int guard;
        int k;
        logic [31:0] mask;
        logic [31:0] thr;

        nrst        = 1'b0;
        sweep_start = 1'b0;
        sv_mask     = '0;
        threshold   = '0;
        res_ready   = 1'b0;
        for (int i = 0; i < 32; i++) begin
            eng_acc[i]  = '0;
            eng_code[i] = 11'($urandom);
            eng_dop[i]  = 5'($urandom);
        end
        step();
        step();
        check_reset_outputs();
        nrst = 1'b1;
        step();

        // Two PRNs, one above threshold
        eng_acc[0] = 32'd1000;
        eng_acc[2] = 32'd10;
        eng_dly_max = 3;
        eng_len_min = 2;
        eng_len_max = 6;
        start_sweep(32'h0000_0005, 32'd500);
        finish_sweep();
        check("two_sv_results", n_res, 1);
        check("two_sv_found", found_mask, 32'h1);

        // Empty mask: done two cycles after the start request, nothing launched
        s0 = n_starts;
        start_sweep(32'h0, 32'd123);
        check("zero_busy", {31'd0, sweep_busy}, 32'd1);
        check("zero_done_early", {31'd0, sweep_done}, 32'd0);
        check("zero_found_cleared", found_mask, 32'd0);
        step();
        check("zero_done", {31'd0, sweep_done}, 32'd1);
        check("zero_idle", {31'd0, sweep_busy}, 32'd0);
        step();
        check("zero_done_pulse", {31'd0, sweep_done}, 32'd0);
        check("zero_no_launch", n_starts, s0);

        // Power equal to threshold is not a detection; fastest engine gives a 5-cycle launch gap
        eng_acc[0] = 32'd500;
        eng_acc[1] = 32'd500;
        eng_dly_max = 0;
        eng_len_min = 2;
        eng_len_max = 2;
        start_sweep(32'h0000_0003, 32'd500);
        finish_sweep();
        check("equal_no_result", n_res, 0);
        check("equal_found", found_mask, 32'd0);
        check("launch_gap", last_gap, 5);

        // Consumer stalls 20 cycles: result held, next SV not launched
        eng_acc[0] = 32'd900;
        eng_acc[1] = 32'd900;
        eng_dly_max = 3;
        eng_len_max = 6;
        ready_mode = 2;
        start_sweep(32'h0000_0003, 32'd100);
        guard = 0;
        while (!res_valid && guard < 100) begin
            step();
            guard++;
        end
        check("stall_reached", {31'd0, res_valid}, 32'd1);
        s0 = n_starts;
        repeat (20) begin
            step();
            check("stall_valid", {31'd0, res_valid}, 32'd1);
        end
        check("stall_no_launch", n_starts, s0);
        check("stall_no_handshake", n_res, 0);
        ready_mode = 1;
        finish_sweep();
        check("stall_results", n_res, 2);

        // Reset while waiting for the engine to finish
        eng_dly_max = 0;
        eng_len_min = 12;
        eng_len_max = 12;
        s0 = n_starts;
        start_sweep(32'h0000_0001, 32'd100);
        guard = 0;
        while (n_starts == s0 && guard < 10) begin
            step();
            guard++;
        end
        check("rst_mid_launched", n_starts, s0 + 1);
        repeat (4) step();
        exp_launch.delete();
        exp_res.delete();
        nrst = 1'b0;
        step();
        check_reset_outputs();
        nrst = 1'b1;
        repeat (15) step();
        check("rst_mid_no_done", n_done, 0);
        check("rst_mid_idle", {31'd0, sweep_busy}, 32'd0);
        check("rst_mid_no_relaunch", n_starts, s0 + 1);

        // Randomized sweeps with random consumer back-pressure and ignored mid-sweep starts
        eng_dly_max  = 3;
        eng_len_min  = 2;
        eng_len_max  = 6;
        ready_mode   = 0;
        mid_start_en = 1;
        for (int t = 0; t < 9; t++) begin
            for (int i = 0; i < 32; i++) begin
                eng_acc[i]  = $urandom;
                eng_code[i] = 11'($urandom);
                eng_dop[i]  = 5'($urandom);
            end
            case (t % 3)
                0:       mask = $urandom;
                1:       mask = $urandom & $urandom & $urandom;
                default: mask = 32'h8000_0001 | (32'd1 << $urandom_range(30, 1));
            endcase
            case (t % 4)
                0:       thr = $urandom;
                1:       thr = eng_acc[$urandom_range(31, 0)];
                2:       thr = 32'd0;
                default: thr = 32'hffff_ffff;
            endcase
            start_sweep(mask, thr);
            finish_sweep();
        end
        mid_start_en = 0;
        ready_mode   = 1;

`ifdef L1CA_ACQ_TIMEOUT_EN
        // Engine never finishes: each SV times out and the next is launched
        eng_stuck = 1;
        step();
        s0 = n_starts;
        start_sweep(32'h0000_0003, 32'hffff_ffff);
        guard = 0;
        while (n_starts == s0 && guard < 10) begin
            step();
            guard++;
        end
        k = 0;
        while (!timeout_flag && k < 300) begin
            step();
            k++;
        end
        // Detected in cycle 100 after LAUNCH, visible from the following cycle
        check("timeout_latency", k, 101);
        step();
        check("timeout_next_launch", n_starts, s0 + 2);
        exp_tflag = 1'b1;
        finish_sweep();
        eng_stuck = 0;
        exp_tflag = 1'b0;
        step();
        step();
        start_sweep(32'h0, 32'd0);
        check("timeout_cleared", {31'd0, timeout_flag}, 32'd0);
        finish_sweep();
`else
        k = 0;
        check("timeout_absent", {31'd0, timeout_flag}, 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", chk, errs);
        $finish;
    end

endmodule
